result_mem_reader: RTL

//   Reads result matrices that the pipeline writes into the data memory
//   (MemData, 128-bit words: 4 rows x 4 bytes) and streams them out byte by

---
 rtl/result_mem_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/result_mem_reader.sv
// result_mem_reader: reads DATA_W-bit result words from the data memory and
// streams them out MSB byte first over a valid/ready byte interface.
module result_mem_reader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 128,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              mem_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_hold;
  logic [ADDR_W-1:0] words_left;
  logic [BC_W-1:0]   byte_cnt;
  logic [1:0]        lat_cnt;
  logic [DATA_W-1:0] shreg;

  logic accept, word_end, last_word, lat_hit;

  // Handshake and word-boundary qualifiers shared by FSM and datapath
  always_comb begin
    accept    = (state == SEND) && out_ready;
    word_end  = accept && (byte_cnt == BC_W'(BYTES - 1));
    last_word = (words_left == ADDR_W'(1));
    lat_hit   = (lat_cnt == 2'(READ_LAT - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (num_words == '0) ? DONE : REQ;
      REQ:  if (!mem_busy) state_nx = WAIT;
      WAIT: if (lat_hit) state_nx = SEND;
      SEND: if (word_end) state_nx = last_word ? DONE : REQ;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode; the address port shows the live address only while reading
  // and otherwise replays the last issued one, so advancing cur_addr at the end
  // of a word never disturbs mem_addr between reads.
  always_comb begin
    mem_rden  = (state == REQ) && !mem_busy;
    mem_addr  = mem_rden ? cur_addr : addr_hold;
    out_valid = (state == SEND);
    out_data  = shreg[DATA_W-1 -: 8];
    out_last  = out_valid && (byte_cnt == BC_W'(BYTES - 1)) && last_word;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Transfer parameters, read latency counter and byte shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr   <= '0;
      addr_hold  <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
      lat_cnt    <= '0;
      shreg      <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur_addr   <= base_addr;
        words_left <= num_words;
      end else if (word_end && !last_word) begin
        cur_addr   <= cur_addr + ADDR_W'(1);
        words_left <= words_left - ADDR_W'(1);
      end

      if (mem_rden) addr_hold <= cur_addr;

      if (state == REQ)       lat_cnt <= '0;
      else if (state == WAIT) lat_cnt <= lat_cnt + 2'd1;

      if (state == WAIT && lat_hit) begin
        shreg    <= mem_q;
        byte_cnt <= '0;
      end else if (accept) begin
        shreg    <= shreg << 8;
        byte_cnt <= byte_cnt + BC_W'(1);
      end
    end
  end

endmodule
